fir_sterowanie: RTL and testbench
=================================

# fir_sterowanie

FIR sequencing controller that runs the filter over the sample buffer once per start command. It takes the input-RAM and output-RAM address muxes away from the AXI path and walks each output index n and tap index k. It reads x[n−k] and h[k], accumulates products in Q15, and writes each saturated result into the output RAM at address n. It sits beside the AXI/RAM wrapper and drives that wrapper's FSM-side signals: mux selects, shared sample address, output write strobe and result data.

## Interface
Parameters:
- ADDR_WIDTH, 13, width of sample and coefficient RAM addresses and of the count inputs.
- DATA_WIDTH, 16, width of samples, coefficients and results (signed Q15).
- ACC_WIDTH, 40, width of the signed accumulator.

Ports:
- a_clk  in  1  single clock.
- a_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command pulse; sampled only in IDLE.
- n_probek  in  ADDR_WIDTH  number of samples to filter; latched at start.
- n_wsp  in  ADDR_WIDTH  number of taps; latched at start.
- probka  in  DATA_WIDTH  input-RAM read data (registered read, 1-cycle latency).
- wsp  in  DATA_WIDTH  coefficient-RAM read data (registered read, 1-cycle latency).
- fsm_mux_wej  out  1  1 = input-RAM address taken from adres_probki_fir.
- fsm_mux_wyj  out  1  1 = output-RAM address taken from adres_probki_fir.
- adres_probki_fir  out  ADDR_WIDTH  shared address: n−k in RD, n in WR, else 0.
- adres_wsp  out  ADDR_WIDTH  coefficient address k in RD, else 0.
- fsm_wyj_wr  out  1  output-RAM write enable.
- fir_probka_wynik  out  DATA_WIDTH  result data, valid while fsm_wyj_wr = 1.
- busy  out  1  high in CLR, RD, MAC and WR.
- done  out  1  one-cycle completion pulse.

## Operation
- States are IDLE, CLR, RD, MAC, WR and DONE.
- IDLE:
  - start=1 latches n_probek and n_wsp, and sets n=0.
  - If n_probek=0, go to DONE; otherwise go to CLR.
- CLR: set acc=0 and k=0. Compute L = min(n, n_wsp−1).
  - If n_wsp=0, go to WR, which writes 0.
  - Otherwise go to RD.
- RD: drive adres_probki_fir=n−k and adres_wsp=k. The RAMs capture these addresses at the closing edge. Go to MAC.
- MAC:
  - acc += sign-extended probka × wsp (full 2·DATA_WIDTH-bit signed product).
  - If k=L, go to WR; otherwise k++ and go to RD.
- WR:
  - fsm_wyj_wr=1, adres_probki_fir=n.
  - fir_probka_wynik = sat(acc >>> 15): arithmetic shift (floor, no rounding), then clamp to [0x8000, 0x7FFF].
  - If n=n_probek−1, go to DONE; otherwise n++ and go to CLR.
- DONE: done=1 for one cycle, then IDLE.
- Mux selects:
  - fsm_mux_wej = fsm_mux_wyj = busy.
  - Both are 0 in IDLE and DONE, so AXI owns both RAMs there.
- Address bounds: k ≤ n always, so n−k never wraps. Taps beyond n are skipped (zero history, no read).
- start while busy or in DONE is ignored. Inputs n_probek and n_wsp may change freely after start.

## Timing
- All outputs are registered or decoded from the state register. Cycle c is the cycle in which start=1 is sampled.
- Cycle 1 to c+1 + Σ_n(2 + 2·(L_n+1)) − 1 is the run; done is asserted in the cycle after the last WR.
- Sample n costs 1 CLR + 2 cycles per tap + 1 WR. With n_wsp=0 each sample costs 2 cycles (CLR, WR).
- n_probek=0: done asserted in cycle c+1, no write occurs.
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - acc, n and k are 0.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No further write and no done pulse; a partially written output RAM is left as is.
- Addresses presented in RD pair with probka/wsp consumed in the following MAC cycle, with no bubbles.

## Test plan
- Reset check: hold a_rst_n=0 → every output is 0. Release with start=0 → stays IDLE, busy=0.
- Single sample: n_probek=1, n_wsp=1, x0=0x4000, h0=0x4000.
  - Required: WR in cycle c+4 with address 0 and data 0x2000; done in c+5.
  - Mux selects are high only in c+1..c+4.
- Short run: n_probek=4, n_wsp=2, h={0x4000,0x4000}, x={0x0100,0x0200,0x0300,0x0400}.
  - Required writes: y={0x0080,0x0180,0x0280,0x0380} at addresses 0..3.
  - Done in cycle c+23.
- Saturation:
  - Positive: x=h=0x7FFF, n_probek=3, n_wsp=3 → y0=0x7FFE, y1=y2=0x7FFF.
  - Negative: x=0x8000, h=0x7FFF, n_wsp=2 → y0=0x8001, y1=0x8000.
- Degenerate counts:
  - n_probek=0 → done at c+1, no fsm_wyj_wr.
  - n_wsp=0, n_probek=2 → writes 0x0000 to addresses 0 and 1, done at c+5.
- Control hazards:
  - A second start pulse mid-run is ignored (same write sequence and done cycle).
  - a_rst_n pulsed low during MAC → outputs 0 immediately, no further writes, no done.
  - A fresh start after the reset pulse runs correctly.

Source files
------------

// File: rtl/fir_sterowanie.sv
// FIR sequencing controller: walks output index n and tap index k over the RAMs,
// accumulates Q15 products and writes each saturated result to the output RAM.
module fir_sterowanie #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         a_clk,
  input  logic                         a_rst_n,
  input  logic                         start,
  input  logic        [ADDR_WIDTH-1:0] n_probek,
  input  logic        [ADDR_WIDTH-1:0] n_wsp,
  input  logic signed [DATA_WIDTH-1:0] probka,
  input  logic signed [DATA_WIDTH-1:0] wsp,
  output logic                         fsm_mux_wej,
  output logic                         fsm_mux_wyj,
  output logic        [ADDR_WIDTH-1:0] adres_probki_fir,
  output logic        [ADDR_WIDTH-1:0] adres_wsp,
  output logic                         fsm_wyj_wr,
  output logic signed [DATA_WIDTH-1:0] fir_probka_wynik,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {IDLE, CLR, RD, MAC, WR, DONE} state_t;

  localparam int FRAC = DATA_WIDTH - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic        [ADDR_WIDTH-1:0]   n, k, l;
  logic        [ADDR_WIDTH-1:0]   n_probek_q, n_wsp_q;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Floor shift back to Q15, then clamp to the representable result range.
  function automatic logic signed [DATA_WIDTH-1:0] sat_q15(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> FRAC;
    if (s > SAT_MAX) s = SAT_MAX;
    else if (s < SAT_MIN) s = SAT_MIN;
    return s[DATA_WIDTH-1:0];
  endfunction

  assign prod = (2*DATA_WIDTH)'(probka) * (2*DATA_WIDTH)'(wsp);

  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    busy             = 1'b0;
    done             = 1'b0;
    fsm_wyj_wr       = 1'b0;
    adres_probki_fir = '0;
    adres_wsp        = '0;
    fir_probka_wynik = '0;
    unique case (state)
      IDLE: if (start) state_nxt = (n_probek == '0) ? DONE : CLR;
      CLR: begin
        busy      = 1'b1;
        state_nxt = (n_wsp_q == '0) ? WR : RD;
      end
      RD: begin
        busy             = 1'b1;
        adres_probki_fir = n - k;
        adres_wsp        = k;
        state_nxt        = MAC;
      end
      MAC: begin
        busy      = 1'b1;
        state_nxt = (k == l) ? WR : RD;
      end
      WR: begin
        busy             = 1'b1;
        fsm_wyj_wr       = 1'b1;
        adres_probki_fir = n;
        fir_probka_wynik = sat_q15(acc);
        state_nxt        = (n == n_probek_q - 1'b1) ? DONE : CLR;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    fsm_mux_wej = busy;
    fsm_mux_wyj = busy;
  end

  // Sample/tap indices and accumulator; the last tap index is min(n, n_wsp-1).
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      n          <= '0;
      k          <= '0;
      l          <= '0;
      n_probek_q <= '0;
      n_wsp_q    <= '0;
      acc        <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          n_probek_q <= n_probek;
          n_wsp_q    <= n_wsp;
          n          <= '0;
        end
        CLR: begin
          acc <= '0;
          k   <= '0;
          l   <= (n < n_wsp_q - 1'b1) ? n : n_wsp_q - 1'b1;
        end
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod);
          if (k != l) k <= k + 1'b1;
        end
        WR: if (n != n_probek_q - 1'b1) n <= n + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sterowanie.sv
// Bench for fir_sterowanie: RAM models around the controller and a plain-arithmetic
// convolution model that predicts every write and the completion cycle.
module tb_fir_sterowanie;

  logic               a_clk = 1'b0;
  logic               a_rst_n = 1'b0;
  logic               start = 1'b0;
  logic        [12:0] n_probek = '0;
  logic        [12:0] n_wsp = '0;
  logic signed [15:0] probka;
  logic signed [15:0] wsp;
  logic               fsm_mux_wej, fsm_mux_wyj, fsm_wyj_wr, busy, done;
  logic        [12:0] adres_probki_fir, adres_wsp;
  logic signed [15:0] fir_probka_wynik;

  fir_sterowanie #(.ADDR_WIDTH(13), .DATA_WIDTH(16), .ACC_WIDTH(40)) dut (
    .a_clk(a_clk), .a_rst_n(a_rst_n), .start(start),
    .n_probek(n_probek), .n_wsp(n_wsp), .probka(probka), .wsp(wsp),
    .fsm_mux_wej(fsm_mux_wej), .fsm_mux_wyj(fsm_mux_wyj),
    .adres_probki_fir(adres_probki_fir), .adres_wsp(adres_wsp),
    .fsm_wyj_wr(fsm_wyj_wr), .fir_probka_wynik(fir_probka_wynik),
    .busy(busy), .done(done)
  );

  always #5 a_clk = ~a_clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic signed [15:0] x_mem [64];
  logic signed [15:0] h_mem [64];

  int          wr_addr [$];
  logic [15:0] wr_data [$];
  int          wr_cyc  [$];
  int          done_q  [$];
  int          busy_n, busy_first, mux_bad;

  always @(posedge a_clk) cyc <= cyc + 1;

  always @(posedge a_clk) begin
    probka <= x_mem[adres_probki_fir[5:0]];
    wsp    <= h_mem[adres_wsp[5:0]];
  end

  always @(negedge a_clk) begin
    if (fsm_wyj_wr) begin
      wr_addr.push_back(int'(adres_probki_fir));
      wr_data.push_back(fir_probka_wynik);
      wr_cyc.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (busy) begin
      busy_n++;
      if (busy_first < 0) busy_first = cyc;
    end
    if (fsm_mux_wej !== busy || fsm_mux_wyj !== busy) mux_bad++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_y(input int n, input int nw);
    longint acc = 0;
    longint s;
    for (int k = 0; k < nw && k <= n; k++)
      acc += longint'(x_mem[n-k]) * longint'(h_mem[k]);
    s = acc >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic int sample_cost(input int n, input int nw);
    int taps;
    if (nw == 0) return 2;
    taps = (n < nw - 1) ? n + 1 : nw;
    return 2 + 2 * taps;
  endfunction

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_q.delete();
    busy_n = 0; busy_first = -1; mux_bad = 0;
  endtask

  // Issue start, optionally pulse start again mid-run, wait (bounded) for done.
  task automatic run(input int np, input int nw, input int restart_at, output int c);
    clear_logs();
    @(negedge a_clk);
    n_probek = 13'(np); n_wsp = 13'(nw); start = 1'b1; c = cyc;
    @(negedge a_clk);
    start = 1'b0; n_probek = 13'($urandom); n_wsp = 13'($urandom);
    for (int i = 0; i < 600 && done_q.size() == 0; i++) begin
      start = (restart_at != 0 && cyc == c + restart_at);
      @(negedge a_clk);
    end
    start = 1'b0;
    repeat (4) @(negedge a_clk);
  endtask

  task automatic check_run(input string tag, input int np, input int nw, input int c);
    int t = c;
    chk({tag, "_nwrites"}, wr_addr.size(), np);
    for (int n = 0; n < np; n++) begin
      t += sample_cost(n, nw);
      if (n < wr_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, n), wr_addr[n], n);
        chk($sformatf("%s_data%0d", tag, n), wr_data[n], ref_y(n, nw));
        chk($sformatf("%s_wrcyc%0d", tag, n), wr_cyc[n], t);
      end
    end
    chk({tag, "_ndone"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, "_donecyc"}, done_q[0], (np == 0) ? c + 1 : t + 1);
    chk({tag, "_mux"}, mux_bad, 0);
  endtask

  initial begin
    int c, np, nw;
    for (int i = 0; i < 64; i++) begin x_mem[i] = '0; h_mem[i] = '0; end
    clear_logs();

    // reset state
    repeat (3) @(negedge a_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr", fsm_wyj_wr, 0);
    chk("rst_muxw", fsm_mux_wej, 0);
    chk("rst_muxy", fsm_mux_wyj, 0);
    chk("rst_adrp", adres_probki_fir, 0);
    chk("rst_adrw", adres_wsp, 0);
    chk("rst_data", fir_probka_wynik, 0);
    a_rst_n = 1'b1;
    repeat (5) @(negedge a_clk);
    chk("idle_busy", busy, 0);
    chk("idle_writes", wr_addr.size(), 0);
    chk("idle_done", done_q.size(), 0);

    // single sample
    x_mem[0] = 16'h4000; h_mem[0] = 16'h4000;
    run(1, 1, 0, c);
    check_run("single", 1, 1, c);
    if (wr_data.size() > 0) chk("single_const", wr_data[0], 16'h2000);
    chk("single_busy_len", busy_n, 4);
    chk("single_busy_first", busy_first, c + 1);

    // short run
    x_mem[0] = 16'h0100; x_mem[1] = 16'h0200; x_mem[2] = 16'h0300; x_mem[3] = 16'h0400;
    h_mem[0] = 16'h4000; h_mem[1] = 16'h4000;
    run(4, 2, 0, c);
    check_run("short", 4, 2, c);
    if (wr_data.size() == 4) chk("short_y3", wr_data[3], 16'h0380);
    if (done_q.size() > 0) chk("short_done_c23", done_q[0], c + 23);

    // positive saturation
    for (int i = 0; i < 3; i++) begin x_mem[i] = 16'h7FFF; h_mem[i] = 16'h7FFF; end
    run(3, 3, 0, c);
    check_run("satpos", 3, 3, c);
    if (wr_data.size() == 3) begin
      chk("satpos_y0", wr_data[0], 16'h7FFE);
      chk("satpos_y2", wr_data[2], 16'h7FFF);
    end

    // negative saturation
    for (int i = 0; i < 2; i++) begin x_mem[i] = 16'h8000; h_mem[i] = 16'h7FFF; end
    run(2, 2, 0, c);
    check_run("satneg", 2, 2, c);
    if (wr_data.size() == 2) begin
      chk("satneg_y0", wr_data[0], 16'h8001);
      chk("satneg_y1", wr_data[1], 16'h8000);
    end

    // degenerate counts
    run(0, 3, 0, c);
    check_run("np0", 0, 3, c);
    run(2, 0, 0, c);
    check_run("nw0", 2, 0, c);
    if (done_q.size() > 0) chk("nw0_done_c5", done_q[0], c + 5);

    // randomized runs
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 64; i++) begin
        x_mem[i] = 16'($urandom); h_mem[i] = 16'($urandom);
      end
      np = $urandom_range(1, 10);
      nw = $urandom_range(0, 5);
      run(np, nw, 0, c);
      check_run($sformatf("rand%0d", r), np, nw, c);
    end

    // second start mid-run is ignored
    np = 5; nw = 3;
    run(np, nw, 7, c);
    check_run("restart", np, nw, c);

    // reset pulse during a MAC cycle (sample 1, second tap: cycle c+9)
    clear_logs();
    @(negedge a_clk);
    n_probek = 13'd3; n_wsp = 13'd2; start = 1'b1; c = cyc;
    @(negedge a_clk);
    start = 1'b0;
    for (int i = 0; i < 50 && cyc < c + 9; i++) @(negedge a_clk);
    chk("rstmid_at_cycle", cyc, c + 9);
    #1 a_rst_n = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_mux", {fsm_mux_wej, fsm_mux_wyj}, 0);
    chk("rstmid_wr", fsm_wyj_wr, 0);
    chk("rstmid_adr", {adres_probki_fir, adres_wsp}, 0);
    chk("rstmid_data", fir_probka_wynik, 0);
    @(negedge a_clk);
    a_rst_n = 1'b1;
    repeat (30) @(negedge a_clk);
    chk("rstmid_nwrites", wr_addr.size(), 1);
    chk("rstmid_ndone", done_q.size(), 0);

    // fresh run after the reset pulse
    for (int i = 0; i < 64; i++) begin
      x_mem[i] = 16'($urandom); h_mem[i] = 16'($urandom);
    end
    run(6, 4, 0, c);
    check_run("fresh", 6, 4, c);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
